// File: rtl/sparc_ram_responder.sv
// sparc_ram_responder
//   Byte-addressed, big-endian memory responder for the SPARC V8 datapath.
//   It accepts one load/store request at a time from the control unit,
//   waits LATENCY cycles and then completes the request with the MFC
//   handshake. Misaligned or unknown requests end in Mem_Align_Err instead.
//
// Parameters
//   ADDR_WIDTH : byte-address bits decoded (memory is 2^ADDR_WIDTH bytes)
//   LATENCY    : wait cycles between acceptance and MFC (0..15)
//
// Ports
//   Clk           in   clock, rising edge active
//   RESET         in   synchronous active-high reset
//   RAM_enable    in   request strobe, held until MFC or Mem_Align_Err
//   RAM_OpCode    in   SPARC op3 of the request
//   Address       in   byte address (low ADDR_WIDTH bits used)
//   DataIn        in   store data (low byte/halfword for STB/STH)
//   DataOut       out  sign/zero-extended load result
//   MFC           out  memory function complete
//   Mem_Align_Err out  misaligned address or unsupported opcode
module sparc_ram_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        Mem_Align_Err
);

  localparam int         MEM_BYTES = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT       = 4'(LATENCY);

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Access size of an opcode; SZ_NONE marks an unsupported opcode.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    logic [1:0] sz;
    case (op)
      OP_LD, OP_ST:             sz = SZ_WORD;
      OP_LDUH, OP_LDSH, OP_STH: sz = SZ_HALF;
      OP_LDUB, OP_LDSB, OP_STB: sz = SZ_BYTE;
      default:                  sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    logic st;
    case (op)
      OP_ST, OP_STB, OP_STH: st = 1'b1;
      default:               st = 1'b0;
    endcase
    return st;
  endfunction

  // Legal means a known opcode with an address aligned to its access size.
  function automatic logic req_legal(input logic [5:0] op, input logic [1:0] lsb);
    logic ok;
    case (op_size(op))
      SZ_WORD: ok = (lsb == 2'b00);
      SZ_HALF: ok = (lsb[0] == 1'b0);
      SZ_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Assemble the load result from the big-endian bytes at the access address.
  function automatic logic [31:0] load_value(input logic [5:0] op,
                                             input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    logic [31:0] v;
    case (op)
      OP_LD:   v = {b0, b1, b2, b3};
      OP_LDUB: v = {24'h000000, b0};
      OP_LDSB: v = {{24{b0[7]}}, b0};
      OP_LDUH: v = {16'h0000, b0, b1};
      OP_LDSH: v = {{16{b0[7]}}, b0, b1};
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  logic [7:0]            mem_r [MEM_BYTES];
  state_t                state_r;
  logic [3:0]            count_r;
  logic                  armed_r;
  logic [5:0]            op_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           data_r;

  logic [5:0]            cur_op_s;
  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic [31:0]           cur_data_s;
  logic [ADDR_WIDTH-1:0] idx1_s, idx2_s, idx3_s;
  logic                  accept_s;
  logic                  legal_s;
  logic                  enter_done_s;
  logic                  commit_s;
  logic [31:0]           load_val_s;
  logic                  unused_addr_hi_s;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign unused_addr_hi_s = ^Address[31:ADDR_WIDTH];

  // Request fields: live inputs while idle (zero-latency path), latched copy afterwards.
  always_comb begin
    cur_op_s   = op_r;
    cur_addr_s = addr_r;
    cur_data_s = data_r;
    if (state_r == IDLE) begin
      cur_op_s   = RAM_OpCode;
      cur_addr_s = Address[ADDR_WIDTH-1:0];
      cur_data_s = DataIn;
    end else begin
      cur_op_s   = op_r;
      cur_addr_s = addr_r;
      cur_data_s = data_r;
    end
  end

  // Byte lane indices, request decode and the next-edge transition strobes.
  always_comb begin
    idx1_s       = cur_addr_s + ADDR_WIDTH'(1);
    idx2_s       = cur_addr_s + ADDR_WIDTH'(2);
    idx3_s       = cur_addr_s + ADDR_WIDTH'(3);
    // A new request needs one idle edge with RAM_enable low first (armed_r).
    accept_s     = (state_r == IDLE) && RAM_enable && armed_r;
    legal_s      = req_legal(cur_op_s, cur_addr_s[1:0]);
    enter_done_s = (accept_s && legal_s && (LAT == 4'd0)) ||
                   ((state_r == BUSY) && (count_r <= 4'd1));
    // The write commits only on the edge entering DONE, never under reset.
    commit_s     = enter_done_s && op_is_store(cur_op_s) && !RESET;
    load_val_s   = load_value(cur_op_s, mem_r[cur_addr_s], mem_r[idx1_s],
                              mem_r[idx2_s], mem_r[idx3_s]);
  end

  // Memory array write port; contents are intentionally not cleared by reset.
  always_ff @(posedge Clk) begin
    if (commit_s) begin
      case (op_size(cur_op_s))
        SZ_WORD: begin
          mem_r[cur_addr_s] <= cur_data_s[31:24];
          mem_r[idx1_s]     <= cur_data_s[23:16];
          mem_r[idx2_s]     <= cur_data_s[15:8];
          mem_r[idx3_s]     <= cur_data_s[7:0];
        end
        SZ_HALF: begin
          mem_r[cur_addr_s] <= cur_data_s[15:8];
          mem_r[idx1_s]     <= cur_data_s[7:0];
        end
        SZ_BYTE: begin
          mem_r[cur_addr_s] <= cur_data_s[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Request FSM with registered MFC, Mem_Align_Err and DataOut.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_r       <= IDLE;
      count_r       <= 4'd0;
      armed_r       <= 1'b0;
      op_r          <= 6'd0;
      addr_r        <= '0;
      data_r        <= 32'h00000000;
      MFC           <= 1'b0;
      Mem_Align_Err <= 1'b0;
      DataOut       <= 32'h00000000;
    end else begin
      case (state_r)
        IDLE: begin
          MFC           <= 1'b0;
          Mem_Align_Err <= 1'b0;
          if (accept_s) begin
            op_r    <= RAM_OpCode;
            addr_r  <= Address[ADDR_WIDTH-1:0];
            data_r  <= DataIn;
            armed_r <= 1'b0;
            if (!legal_s) begin
              state_r       <= ERR;
              Mem_Align_Err <= 1'b1;
            end else if (LAT == 4'd0) begin
              state_r <= DONE;
              MFC     <= 1'b1;
              if (!op_is_store(RAM_OpCode)) begin
                DataOut <= load_val_s;
              end
            end else begin
              state_r <= BUSY;
              count_r <= LAT;
            end
          end else begin
            // Only an edge seen with RAM_enable low re-arms acceptance.
            armed_r <= !RAM_enable;
          end
        end
        BUSY: begin
          if (count_r <= 4'd1) begin
            state_r <= DONE;
            count_r <= 4'd0;
            MFC     <= 1'b1;
            if (!op_is_store(op_r)) begin
              DataOut <= load_val_s;
            end
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        DONE: begin
          if (!RAM_enable) begin
            state_r <= IDLE;
            MFC     <= 1'b0;
          end
        end
        ERR: begin
          if (!RAM_enable) begin
            state_r       <= IDLE;
            Mem_Align_Err <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          MFC           <= 1'b0;
          Mem_Align_Err <= 1'b0;
        end
      endcase
    end
  end

endmodule
